memory_responder: RTL and testbench

MEMORY_RESPONDER -- requirements
Module: memory_responder

---
 rtl/memory_responder.sv | 169 ++++++++++++++++
 tb/tb_memory_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// Word-addressed single-port memory responder with wait states on nonsequential accesses.
// Define MEMORY_RESPONDER_PROT_CHECK_EN to enable privilege and opcode-write protection aborts.
module memory_responder #(
   parameter int DEPTH      = 8192,
   parameter int WAIT_N     = 2,
   parameter int PRIV_LIMIT = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        write,
   input  logic        size,
   input  logic [1:0]  prot,
   input  logic [1:0]  trans,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        abort
);

   localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] WAIT_LOAD = (WAIT_N > 0) ? 4'(WAIT_N - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

   state_t      state;
   state_t      next_state;

   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic        lat_write;
   logic        lat_size;
   logic [1:0]  lat_prot;
   logic [3:0]  wait_cnt;

   logic        hist_valid;
   logic        hist_abort;
   logic [31:0] hist_addr;

   logic [31:0] mem [DEPTH];
   logic [AW-1:0] mem_idx;

   logic        accept;
   logic        complete;
   logic        range_fault;
   logic        prot_fault;
   logic        cur_fault;
   logic [31:0] prev_addr;
   logic        prev_ok;
   logic        zero_wait;

   assign accept      = ready && trans[1];
   assign complete    = (state == ACCESS);
   assign mem_idx     = lat_addr[AW-1:0];
   assign range_fault = (lat_addr >= 32'(DEPTH));

`ifdef MEMORY_RESPONDER_PROT_CHECK_EN
   assign prot_fault  = (!lat_prot[1] && (lat_addr < 32'(PRIV_LIMIT))) ||
                        (lat_write && !lat_prot[0]);
`else
   // prot is still latched but has no effect on this build
   assign prot_fault  = 1'b0 & (|lat_prot);
`endif

   assign cur_fault   = range_fault || prot_fault;

   // The access completing right now is the "previous" one for a back-to-back request
   always_comb begin
      prev_addr = hist_addr;
      prev_ok   = hist_valid && !hist_abort;
      if (state == ACCESS) begin
         prev_addr = lat_addr;
         prev_ok   = !cur_fault;
      end
      zero_wait = (WAIT_N == 0) ||
                  ((trans == 2'b11) && prev_ok && (addr == prev_addr + 32'd1));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (accept) begin
               next_state = zero_wait ? ACCESS : WAIT;
            end
         end
         WAIT: begin
            if (wait_cnt == 4'd0) begin
               next_state = ACCESS;
            end
         end
         ACCESS: begin
            if (accept) begin
               next_state = zero_wait ? ACCESS : WAIT;
            end else begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      ready = 1'b1;
      if (state == WAIT) begin
         ready = 1'b0;
      end
   end

   // Request latch, wait counter, sequential history and registered responses
   always_ff @(posedge clk) begin
      if (reset) begin
         lat_addr   <= 32'd0;
         lat_wdata  <= 32'd0;
         lat_write  <= 1'b0;
         lat_size   <= 1'b0;
         lat_prot   <= 2'b00;
         wait_cnt   <= 4'd0;
         hist_valid <= 1'b0;
         hist_abort <= 1'b0;
         hist_addr  <= 32'd0;
         rdata      <= 32'd0;
         abort      <= 1'b0;
      end else begin
         abort <= complete && cur_fault;

         if (complete && !cur_fault && !lat_write) begin
            rdata <= lat_size ? mem[mem_idx] : {24'd0, mem[mem_idx][7:0]};
         end

         if (complete) begin
            hist_valid <= 1'b1;
            hist_abort <= cur_fault;
            hist_addr  <= lat_addr;
         end

         if (accept) begin
            lat_addr  <= addr;
            lat_wdata <= wdata;
            lat_write <= write;
            lat_size  <= size;
            lat_prot  <= prot;
            wait_cnt  <= WAIT_LOAD;
         end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
         end
      end
   end

   // Memory contents survive reset; writes only land on a non-faulting completion
   always_ff @(posedge clk) begin
      if (!reset && complete && !cur_fault && lat_write) begin
         if (lat_size) begin
            mem[mem_idx] <= lat_wdata;
         end else begin
            mem[mem_idx][7:0] <= lat_wdata[7:0];
         end
      end
   end

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder: a reference model predicts wait counts,
// read data and abort pulses, which are compared when each access completes.
module tb_memory_responder;

   localparam int DEPTH      = 8192;
   localparam int WAIT_N     = 2;
   localparam int PRIV_LIMIT = 256;

   logic        clk;
   logic        reset;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        write;
   logic        size;
   logic [1:0]  prot;
   logic [1:0]  trans;
   logic [31:0] rdata;
   logic        ready;
   logic        abort;

   typedef struct {
      string       tag;
      logic [31:0] rdata;
      logic        abrt;
   } exp_t;

   exp_t        exp_q[$];
   bit          pend;
   int          test_count;
   int          fail_count;

   logic [31:0] ref_mem [int];
   logic [31:0] exp_rdata;
   logic        last_valid;
   logic        last_abort;
   logic [31:0] last_addr;

   memory_responder #(
      .DEPTH      (DEPTH),
      .WAIT_N     (WAIT_N),
      .PRIV_LIMIT (PRIV_LIMIT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .wdata (wdata),
      .write (write),
      .size  (size),
      .prot  (prot),
      .trans (trans),
      .rdata (rdata),
      .ready (ready),
      .abort (abort)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      test_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   function automatic logic modelFault(input logic [31:0] a, input logic w, input logic [1:0] p);
      logic f;
      f = (a >= 32'(DEPTH));
`ifdef MEMORY_RESPONDER_PROT_CHECK_EN
      f = f || (!p[1] && (a < 32'(PRIV_LIMIT))) || (w && !p[0]);
`else
      if (w && p == 2'b10) f = f;
`endif
      return f;
   endfunction

   // One clock; pops and checks the access that completed on this edge, if any
   task automatic stepCycle();
      exp_t e;
      @(posedge clk);
      #1;
      if (pend) begin
         e = exp_q.pop_front();
         checkOutput({e.tag, " rdata"}, rdata, e.rdata);
         checkOutput({e.tag, " abort"}, 32'(abort), 32'(e.abrt));
         pend = 1'b0;
      end else begin
         checkOutput("abort quiet", 32'(abort), 32'd0);
      end
   endtask

   task automatic idleCycles(input int n);
      trans = 2'b00;
      for (int i = 0; i < n; i++) stepCycle();
   endtask

   // Presents a request while ready=1, predicts its outcome and checks the wait count
   task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] wd,
                                input logic w, input logic sz, input logic [1:0] p, input logic [1:0] tr);
      logic        f;
      logic        seq_hit;
      logic [31:0] m;
      int          exp_waits;
      int          n;
      exp_t        e;
      seq_hit   = (tr == 2'b11) && last_valid && !last_abort && (a == last_addr + 32'd1);
      exp_waits = seq_hit ? 0 : WAIT_N;
      f         = modelFault(a, w, p);
      if (!f) begin
         m = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'd0;
         if (w) ref_mem[int'(a)] = sz ? wd : {m[31:8], wd[7:0]};
         else   exp_rdata = sz ? m : {24'd0, m[7:0]};
      end
      e.tag = tag; e.rdata = exp_rdata; e.abrt = f;
      exp_q.push_back(e);
      last_valid = 1'b1; last_abort = f; last_addr = a;

      addr = a; wdata = wd; write = w; size = sz; prot = p; trans = tr;
      stepCycle();
      trans = 2'b00;
      n = 0;
      while (!ready && n < 40) begin
         stepCycle();
         n++;
      end
      if (n >= 40) checkOutput({tag, " timeout"}, 32'(n), 32'(exp_waits));
      else         checkOutput({tag, " waits"}, 32'(n), 32'(exp_waits));
      pend = 1'b1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_count = 0; fail_count = 0; pend = 1'b0;
      exp_rdata = 32'd0; last_valid = 1'b0; last_abort = 1'b0; last_addr = 32'd0;
      reset = 1'b1; addr = 32'd0; wdata = 32'd0; write = 1'b0; size = 1'b1;
      prot = 2'b11; trans = 2'b00;

      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      checkOutput("reset ready", 32'(ready), 32'd1);
      checkOutput("reset abort", 32'(abort), 32'd0);
      checkOutput("reset rdata", rdata, 32'd0);

      applyStimulus("wr300", 32'd300, 32'hDEADBEEF, 1'b1, 1'b1, 2'b11, 2'b10);
      idleCycles(1);
      applyStimulus("rd300", 32'd300, 32'd0, 1'b0, 1'b1, 2'b11, 2'b10);
      idleCycles(1);

      for (int i = 0; i < 4; i++)
         applyStimulus("wr399+", 32'(399 + i), 32'hA5000000 + 32'(i * 17), 1'b1, 1'b1, 2'b11, 2'b10);
      applyStimulus("wr500", 32'd500, 32'h50050050, 1'b1, 1'b1, 2'b11, 2'b10);
      applyStimulus("rd399", 32'd399, 32'd0, 1'b0, 1'b1, 2'b11, 2'b10);
      applyStimulus("rd400s", 32'd400, 32'd0, 1'b0, 1'b1, 2'b11, 2'b11);
      applyStimulus("rd401s", 32'd401, 32'd0, 1'b0, 1'b1, 2'b11, 2'b11);
      applyStimulus("rd402s", 32'd402, 32'd0, 1'b0, 1'b1, 2'b11, 2'b11);
      applyStimulus("rd500s", 32'd500, 32'd0, 1'b0, 1'b1, 2'b11, 2'b11);
      idleCycles(2);

      applyStimulus("wr700", 32'd700, 32'h11223344, 1'b1, 1'b1, 2'b11, 2'b10);
      applyStimulus("wrb700", 32'd700, 32'hFFFFFFAB, 1'b1, 1'b0, 2'b11, 2'b10);
      applyStimulus("rdw700", 32'd700, 32'd0, 1'b0, 1'b1, 2'b11, 2'b10);
      applyStimulus("rdb700", 32'd700, 32'd0, 1'b0, 1'b0, 2'b11, 2'b10);
      idleCycles(1);

      applyStimulus("wr0", 32'd0, 32'h0BADF00D, 1'b1, 1'b1, 2'b11, 2'b10);
      applyStimulus("rd0", 32'd0, 32'd0, 1'b0, 1'b1, 2'b11, 2'b10);
      applyStimulus("rdoor", 32'(DEPTH), 32'd0, 1'b0, 1'b1, 2'b11, 2'b10);
      idleCycles(2);
      applyStimulus("wroor", 32'(DEPTH), 32'h12345678, 1'b1, 1'b1, 2'b11, 2'b10);
      idleCycles(1);
      applyStimulus("rd0again", 32'd0, 32'd0, 1'b0, 1'b1, 2'b11, 2'b10);
      idleCycles(1);

      applyStimulus("wrtop", 32'(DEPTH - 1), 32'h7F7F0001, 1'b1, 1'b1, 2'b11, 2'b10);
      applyStimulus("rdtop", 32'(DEPTH - 1), 32'd0, 1'b0, 1'b1, 2'b11, 2'b10);
      applyStimulus("rdwrap", 32'(DEPTH), 32'd0, 1'b0, 1'b1, 2'b11, 2'b11);
      applyStimulus("rdafterab", 32'(DEPTH + 1), 32'd0, 1'b0, 1'b1, 2'b11, 2'b11);
      idleCycles(1);

      // Coprocessor cycle carrying a write must touch nothing
      addr = 32'd300; wdata = 32'h0; write = 1'b1; size = 1'b1; trans = 2'b01;
      stepCycle();
      checkOutput("cop ready", 32'(ready), 32'd1);
      checkOutput("cop rdata", rdata, exp_rdata);
      idleCycles(1);
      applyStimulus("rd300cop", 32'd300, 32'd0, 1'b0, 1'b1, 2'b11, 2'b10);
      idleCycles(1);

      applyStimulus("wr10init", 32'd10, 32'h10101010, 1'b1, 1'b1, 2'b11, 2'b10);
      applyStimulus("wr10user", 32'd10, 32'h0000AAAA, 1'b1, 1'b1, 2'b01, 2'b10);
      applyStimulus("rd10a", 32'd10, 32'd0, 1'b0, 1'b1, 2'b11, 2'b10);
      applyStimulus("wr10priv", 32'd10, 32'hCAFEF00D, 1'b1, 1'b1, 2'b11, 2'b10);
      applyStimulus("rd10b", 32'd10, 32'd0, 1'b0, 1'b1, 2'b11, 2'b10);
      idleCycles(1);

      applyStimulus("wr600", 32'd600, 32'h00000600, 1'b1, 1'b1, 2'b11, 2'b10);
      applyStimulus("rd600", 32'd600, 32'd0, 1'b0, 1'b1, 2'b11, 2'b10);
      idleCycles(1);
      addr = 32'd600; wdata = 32'h99999999; write = 1'b1; size = 1'b1; prot = 2'b11; trans = 2'b10;
      stepCycle();
      trans = 2'b00;
      checkOutput("midwait ready", 32'(ready), 32'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      checkOutput("rstwait ready", 32'(ready), 32'd1);
      checkOutput("rstwait abort", 32'(abort), 32'd0);
      checkOutput("rstwait rdata", rdata, 32'd0);
      exp_rdata = 32'd0; last_valid = 1'b0; last_abort = 1'b0;
      idleCycles(2);
      applyStimulus("rd600rst", 32'd600, 32'd0, 1'b0, 1'b1, 2'b11, 2'b11);
      idleCycles(2);

      if (exp_q.size() != 0) checkOutput("queue drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
